parity_serializer: RTL and testbench
====================================

# parity_serializer

Upstream feeder for the serial parity-check stage. It accepts a parallel data word through a valid/ready handshake and shifts it out LSB-first on a one-bit serial line, then appends one parity bit. A downstream parity checker that starts from its reset state therefore sees even overall parity (or odd, per parameter) after every frame. An optional idle gap separates frames.

## Interface
- DATA_W, 8: data bits per frame; legal range 1–32.
- ODD_PARITY, 0: 0 = appended bit makes the frame even parity; 1 = odd.
- GAP_CYCLES, 0: idle cycles inserted after each parity bit; legal range 0–15.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- din  in  DATA_W  parallel word to serialize.
- din_valid  in  1  din is valid.
- din_ready  out  1  block can accept a word; transfer occurs when din_valid && din_ready at a rising edge.
- x  out  1  serial bit to the downstream checker.
- x_valid  out  1  x carries a frame bit (data or parity).
- frame_start  out  1  high only while x carries data bit 0.
- busy  out  1  a frame or gap is in progress.

## Operation
- The FSM has four states: IDLE, DATA, PAR and GAP. It is held in a parity_serializer_pkg state enum.
- IDLE:
  - din_ready=1, x=0, x_valid=0.
  - On a handshake: shreg<=din, par<=ODD_PARITY, bitcnt<=DATA_W-1, go to DATA.
- DATA:
  - x=shreg[0], x_valid=1.
  - Each cycle: shreg shifts right (zero fill), par<=par^shreg[0], bitcnt decrements.
  - When bitcnt==0, go to PAR.
- PAR:
  - x=par, after all DATA_W bits have been folded in. x_valid=1.
  - Go to GAP with gapcnt<=GAP_CYCLES-1 if GAP_CYCLES>0; otherwise go to IDLE.
- GAP:
  - x=0, x_valid=0.
  - Go to IDLE when gapcnt==0.
- din_ready=(state==IDLE). din_valid is ignored in every other state; a word offered while busy is neither captured nor lost, and stays pending at the source.
- busy=(state!=IDLE).
- Parity rule: XOR of the DATA_W data bits, XORed with the parity bit, equals ODD_PARITY. With ODD_PARITY=0, an even-parity checker's running output returns to its reset value after each clean frame.

## Timing
- Reset values while rst=0: state=IDLE, x=0, x_valid=0, frame_start=0, busy=0, din_ready=1. Handshakes are not honoured while rst=0.
- Reset mid-frame aborts immediately and asynchronously; the partial frame is discarded, with no parity bit emitted.
- Latency: with a handshake at edge k, data bit 0 appears on x in cycle k+1 and the parity bit in cycle k+1+DATA_W.
- x_valid stays high for exactly DATA_W+1 consecutive cycles per frame.
- Minimum frame period is DATA_W+2+GAP_CYCLES cycles (IDLE, data bits, parity bit, gap). Back-to-back accepts are spaced by exactly this amount when din_valid is held high.
- All outputs are decoded from flops only; there is no combinational path from din or din_valid to any output.
- Counter widths: bitcnt is $clog2(DATA_W) bits, minimum 1; gapcnt is 4 bits.
- DATA_W=1 is legal: one data cycle, then PAR.

## Structure
- parity_serializer_pkg holds the state_t enum (IDLE, DATA, PAR, GAP) and the GAP_W=4 constant.
- One sub-module, parity_serializer_cnt: a loadable down-counter with a zero flag, instantiated twice (bit counter and gap counter).
- The shift register, parity flop and FSM live in the top module.

## Test plan
All scenarios use DATA_W=8.
- din=8'hA5, ODD_PARITY=0 → x reads 1,0,1,0,0,1,0,1 then parity 0; x_valid high for 9 cycles; frame_start high on the first cycle only.
- din=8'h01 → parity bit 1. A chained even-parity checker's z is back at its reset value after the frame.
- ODD_PARITY=1, din=8'h00 → eight 0s then parity 1.
- GAP_CYCLES=2, din_valid held high with 8'hFF then 8'h0F → the second handshake occurs exactly 12 cycles after the first; parity bits are 0 and 0; x_valid is low for 3 cycles between frames.
- din_valid pulsed for one cycle during DATA with 8'h55 → not captured; the current frame is unchanged; din_ready stays 0 until IDLE.
- rst driven low after the 3rd data bit of 8'hC3 → x and x_valid drop to 0 without waiting for a clock edge. After release, 8'h3C serializes from bit 0 with parity 0.

Source files
------------

// File: rtl/parity_serializer_pkg.sv
// Shared types and constants for the parity serializer.
package parity_serializer_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PAR, GAP} state_t;
  localparam int GAP_W = 4;
endpackage

// File: rtl/parity_serializer_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
module parity_serializer_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/parity_serializer.sv
// Serializes a parallel word LSB-first, appends a parity bit, then idles GAP_CYCLES.
module parity_serializer
  import parity_serializer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              x,
  output logic              x_valid,
  output logic              frame_start,
  output logic              busy
);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0]    BIT_LOAD = BW'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shnext;
  logic              par;
  logic              accept;
  logic              bit_zero;
  logic              gap_zero;

  assign accept = (state == IDLE) && din_valid;
  assign shnext = shreg >> 1;

  parity_serializer_cnt #(.W(BW)) u_bitcnt (
    .clk(clk), .rst(rst), .load(accept), .load_val(BIT_LOAD),
    .dec(state == DATA), .zero(bit_zero)
  );

  parity_serializer_cnt #(.W(GAP_W)) u_gapcnt (
    .clk(clk), .rst(rst), .load(state == PAR), .load_val(GAP_LOAD),
    .dec(state == GAP), .zero(gap_zero)
  );

  // Outputs are registered with next-cycle values so x lines up with the state it describes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      par         <= 1'b0;
      x           <= 1'b0;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      din_ready   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (din_valid) begin
          state       <= DATA;
          shreg       <= din;
          par         <= (ODD_PARITY != 0);
          x           <= din[0];
          x_valid     <= 1'b1;
          frame_start <= 1'b1;
          busy        <= 1'b1;
          din_ready   <= 1'b0;
        end
        DATA: begin
          shreg       <= shnext;
          par         <= par ^ shreg[0];
          frame_start <= 1'b0;
          if (bit_zero) begin
            state <= PAR;
            x     <= par ^ shreg[0];
          end else begin
            x <= shnext[0];
          end
        end
        PAR: begin
          x       <= 1'b0;
          x_valid <= 1'b0;
          if (GAP_CYCLES > 0) begin
            state <= GAP;
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            din_ready <= 1'b1;
          end
        end
        GAP: if (gap_zero) begin
          state     <= IDLE;
          busy      <= 1'b0;
          din_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_parity_serializer.sv
// Scoreboard bench: even DUT (gap 2) and odd DUT (no gap), both DATA_W=8.
module tb_parity_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din_e = '0, din_o = '0;
  logic       dv_e = 1'b0, dv_o = 1'b0;
  logic       rdy_e, x_e, xv_e, fs_e, busy_e;
  logic       rdy_o, x_o, xv_o, fs_o, busy_o;

  typedef struct {logic x; logic fs;} exp_t;
  exp_t q_e[$], q_o[$];
  int   checks = 0, errors = 0;
  int   run_e = 0, low_e = 0, last_low_e = 0, run_o = 0;
  logic z_e = 1'b0, z_o = 1'b0;

  always #5 clk = ~clk;

  parity_serializer #(.DATA_W(8), .ODD_PARITY(0), .GAP_CYCLES(2)) u_even (
    .clk(clk), .rst(rst), .din(din_e), .din_valid(dv_e), .din_ready(rdy_e),
    .x(x_e), .x_valid(xv_e), .frame_start(fs_e), .busy(busy_e));

  parity_serializer #(.DATA_W(8), .ODD_PARITY(1), .GAP_CYCLES(0)) u_odd (
    .clk(clk), .rst(rst), .din(din_o), .din_valid(dv_o), .din_ready(rdy_o),
    .x(x_o), .x_valid(xv_o), .frame_start(fs_o), .busy(busy_o));

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++; errors++;
    $display("FAIL %s actual=x_valid_1 required=no_pending_bit at %0t", name, $time);
  endtask

  // Even monitor: bit/frame_start order, frame length, chained even checker z, idle run.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      run_e = 0; low_e = 0; z_e = 1'b0;
    end else if (xv_e) begin
      if (run_e == 0) last_low_e = low_e;
      low_e = 0;
      if (q_e.size() == 0) unexpected("even_unexpected_bit");
      else begin
        e = q_e.pop_front();
        chk("even_x", int'(x_e), int'(e.x));
        chk("even_frame_start", int'(fs_e), int'(e.fs));
      end
      z_e = z_e ^ x_e;
      run_e++;
    end else begin
      if (run_e != 0) begin
        chk("even_xvalid_len", run_e, 9);
        chk("even_checker_z", int'(z_e), 0);
      end
      run_e = 0;
      low_e++;
    end
  end

  // Odd monitor: same, but the running xor must end at 1.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      run_o = 0; z_o = 1'b0;
    end else if (xv_o) begin
      if (q_o.size() == 0) unexpected("odd_unexpected_bit");
      else begin
        e = q_o.pop_front();
        chk("odd_x", int'(x_o), int'(e.x));
        chk("odd_frame_start", int'(fs_o), int'(e.fs));
      end
      z_o = z_o ^ x_o;
      run_o++;
    end else begin
      if (run_o != 0) begin
        chk("odd_xvalid_len", run_o, 9);
        chk("odd_checker_z", int'(z_o), 1);
      end
      run_o = 0;
      z_o = 1'b0;
    end
  end

  // Offer w, wait for the handshake edge, push the 9 expected bits; t = cycle of the handshake edge.
  task automatic send_e(input logic [7:0] w, input logic p, output int t);
    bit done = 0;
    t = -1;
    @(negedge clk);
    din_e = w; dv_e = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (rdy_e) begin
        for (int i = 0; i < 8; i++) q_e.push_back('{x: w[i], fs: (i == 0)});
        q_e.push_back('{x: p, fs: 1'b0});
        done = 1;
        @(posedge clk);
        t = int'($time / 10);
        #1 dv_e = 1'b0;
      end else @(negedge clk);
    end
    if (!done) begin
      checks++; errors++; dv_e = 1'b0;
      $display("FAIL even_handshake_timeout actual=no_ready required=ready");
    end
  endtask

  task automatic send_o(input logic [7:0] w, input logic p);
    bit done = 0;
    @(negedge clk);
    din_o = w; dv_o = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (rdy_o) begin
        for (int i = 0; i < 8; i++) q_o.push_back('{x: w[i], fs: (i == 0)});
        q_o.push_back('{x: p, fs: 1'b0});
        done = 1;
        @(posedge clk);
        #1 dv_o = 1'b0;
      end else @(negedge clk);
    end
    if (!done) begin
      checks++; errors++; dv_o = 1'b0;
      $display("FAIL odd_handshake_timeout actual=no_ready required=ready");
    end
  endtask

  initial begin
    int t1, t2;
    // Reset state, with din_valid asserted to show it is ignored during reset.
    dv_e = 1'b1; din_e = 8'hAA;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", int'(rdy_e), 1);
    chk("rst_x", int'(x_e), 0);
    chk("rst_xvalid", int'(xv_e), 0);
    chk("rst_frame_start", int'(fs_e), 0);
    chk("rst_busy", int'(busy_e), 0);
    chk("rst_odd_busy", int'(busy_o), 0);
    dv_e = 1'b0;
    @(negedge clk); rst = 1'b1;

    // A5: 1,0,1,0,0,1,0,1 then parity 0; first bit one cycle after the handshake.
    send_e(8'hA5, 1'b0, t1);
    @(negedge clk); #1;
    chk("first_bit_latency", int'(fs_e), 1);
    chk("busy_in_frame", int'(busy_e), 1);

    // 01: parity 1.
    send_e(8'h01, 1'b1, t1);

    // FF then 0F back-to-back with gap 2: accepts 12 cycles apart, 3 idle cycles between.
    send_e(8'hFF, 1'b0, t1);
    send_e(8'h0F, 1'b0, t2);
    chk("accept_spacing", t2 - t1, 12);
    @(negedge clk); #1;
    chk("interframe_low", last_low_e, 3);

    // 55 pulsed during a frame of 96 must be ignored.
    send_e(8'h96, 1'b0, t1);
    repeat (2) @(negedge clk);
    din_e = 8'h55; dv_e = 1'b1;
    @(posedge clk); #1 dv_e = 1'b0;
    for (int n = 0; n < 40 && busy_e; n++) begin
      @(negedge clk); #1;
      if (busy_e) chk("ready_low_while_busy", int'(rdy_e), 0);
    end
    chk("frame_done", int'(busy_e), 0);
    repeat (15) @(negedge clk);

    // C3 aborted by reset after the 3rd data bit.
    send_e(8'hC3, 1'b0, t1);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("abort_xvalid", int'(xv_e), 0);
    chk("abort_x", int'(x_e), 0);
    chk("abort_busy", int'(busy_e), 0);
    chk("abort_ready", int'(rdy_e), 1);
    q_e.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 3C restarts cleanly from bit 0, parity 0.
    send_e(8'h3C, 1'b0, t1);
    @(negedge clk); #1;
    chk("restart_frame_start", int'(fs_e), 1);

    // Odd parity instance: 00 -> parity 1; 07 -> parity 0.
    send_o(8'h00, 1'b1);
    send_o(8'h07, 1'b0);

    for (int n = 0; n < 200 && (q_e.size() != 0 || q_o.size() != 0); n++) @(negedge clk);
    chk("even_queue_drained", q_e.size(), 0);
    chk("odd_queue_drained", q_o.size(), 0);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
